// File: rtl/seq_num_alloc_pkg.sv
// Shared sequence-number helpers for the allocator and the squash-unit age logic.
// Numbers are carried in a wide container and reduced modulo 2^nbits, so one
// set of helpers serves every window width.
package SeqNumPkg;

  localparam int unsigned c_seq_num_bits_dflt = 5;
  localparam int unsigned c_seq_wide_bits     = 16;

  typedef logic [c_seq_num_bits_dflt-1:0] seq_num_t;
  typedef logic [c_seq_wide_bits-1:0]     seq_wide_t;

  // Distance of a from base, modulo 2^nbits
  function automatic seq_wide_t seq_offset(input seq_wide_t a, input seq_wide_t base,
                                           input int unsigned nbits);
    seq_wide_t mask;
    mask = (seq_wide_t'(1) << nbits) - seq_wide_t'(1);
    return (a - base) & mask;
  endfunction

  // True when a was allocated before b, measured from the window head
  function automatic logic is_older(input seq_wide_t a, input seq_wide_t b,
                                    input seq_wide_t head, input int unsigned nbits);
    return seq_offset(a, head, nbits) < seq_offset(b, head, nbits);
  endfunction

endpackage

// File: rtl/seq_num_alloc_if.sv
// Decode/commit/squash bundle of the sequence-number allocator.
// master = client side (decode, commit path, squash grant); slave = allocator.
interface seq_num_alloc_if
  import SeqNumPkg::*;
#(
  parameter int unsigned p_seq_num_bits = c_seq_num_bits_dflt
);
  logic                      alloc_val;
  logic                      alloc_rdy;
  logic [p_seq_num_bits-1:0] alloc_seq_num;
  logic                      commit_val;
  logic [p_seq_num_bits-1:0] commit_seq_num;
  logic                      squash_val;
  logic [p_seq_num_bits-1:0] squash_seq_num;
  logic [p_seq_num_bits-1:0] head_seq_num;
  logic [p_seq_num_bits:0]   num_in_flight;
  logic                      empty;
  logic                      full;

  modport master (
    output alloc_val, commit_val, commit_seq_num, squash_val, squash_seq_num,
    input  alloc_rdy, alloc_seq_num, head_seq_num, num_in_flight, empty, full
  );

  modport slave (
    input  alloc_val, commit_val, commit_seq_num, squash_val, squash_seq_num,
    output alloc_rdy, alloc_seq_num, head_seq_num, num_in_flight, empty, full
  );
endinterface

// File: rtl/seq_window_ptr.sv
// Wrap-bit window pointer: holds its value, increments, or loads a new value.
// A load takes priority over an increment.
module seq_window_ptr #(
  parameter int unsigned p_width = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               load,
  input  logic [p_width-1:0] load_val,
  output logic [p_width-1:0] ptr
);
  logic [p_width-1:0] ptr_d;
  logic [p_width-1:0] ptr_q;

  // Next pointer value: load beats increment, otherwise hold
  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = load_val;
    end else if (inc) begin
      ptr_d = ptr_q + p_width'(1);
    end
  end

  // Pointer register, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
endmodule

// File: rtl/seq_num_alloc.sv
// Sequence-number allocator and in-flight window controller.
// Head/tail carry one extra wrap bit so a full window is distinguishable from
// an empty one. Optional macro SEQ_NUM_ALLOC_CHECK_EN adds simulation-only
// protocol checks and a detailed trace string; datapath behaviour is unchanged.
module seq_num_alloc
  import SeqNumPkg::*;
#(
  parameter int unsigned p_seq_num_bits = 5
) (
  input  logic           clk,
  input  logic           rst,
  seq_num_alloc_if.slave bus
);
  localparam int unsigned c_ptr_bits = p_seq_num_bits + 1;
  localparam logic [c_ptr_bits-1:0] c_capacity = {1'b1, {p_seq_num_bits{1'b0}}};

  logic [c_ptr_bits-1:0]     head_ptr;
  logic [c_ptr_bits-1:0]     tail_ptr;
  logic [c_ptr_bits-1:0]     occupancy;
  logic [c_ptr_bits-1:0]     tail_load_val;
  logic [p_seq_num_bits-1:0] head_seq;
  logic [p_seq_num_bits-1:0] squash_dist;
  logic                      full_w;
  logic                      empty_w;
  logic                      alloc_fire;
  logic                      commit_ok;
  logic                      squash_ok;

  // Window occupancy and status derived purely from the registered pointers
  always_comb begin
    occupancy = tail_ptr - head_ptr;
    head_seq  = head_ptr[p_seq_num_bits-1:0];
    full_w    = (occupancy == c_capacity);
    empty_w   = (occupancy == '0);
  end

  // Qualify alloc, commit and squash against the pre-edge window; a squash
  // rewinds the tail to just past the surviving instruction
  always_comb begin
    alloc_fire    = bus.alloc_val && !full_w && !bus.squash_val;
    commit_ok     = bus.commit_val && !empty_w && (bus.commit_seq_num == head_seq);
    squash_dist   = p_seq_num_bits'(seq_offset(seq_wide_t'(bus.squash_seq_num),
                                               seq_wide_t'(head_seq), p_seq_num_bits));
    squash_ok     = bus.squash_val && ({1'b0, squash_dist} < occupancy);
    tail_load_val = head_ptr + {1'b0, squash_dist} + c_ptr_bits'(1);
  end

  seq_window_ptr #(.p_width(c_ptr_bits)) u_head_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc      (commit_ok),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (head_ptr)
  );

  seq_window_ptr #(.p_width(c_ptr_bits)) u_tail_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc      (alloc_fire),
    .load     (squash_ok),
    .load_val (tail_load_val),
    .ptr      (tail_ptr)
  );

  assign bus.alloc_rdy     = !full_w && !bus.squash_val;
  assign bus.alloc_seq_num = tail_ptr[p_seq_num_bits-1:0];
  assign bus.head_seq_num  = head_seq;
  assign bus.num_in_flight = occupancy;
  assign bus.empty         = empty_w;
  assign bus.full          = full_w;

`ifdef SEQ_NUM_ALLOC_CHECK_EN
  logic [31:0] cycle_cnt_d;
  logic [31:0] cycle_cnt_q;

  // Free-running cycle count used to timestamp protocol reports
  always_comb begin
    cycle_cnt_d = cycle_cnt_q + 32'd1;
  end

  // Cycle counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  // Report requests the allocator silently drops
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (bus.commit_val && empty_w) begin
        $error("seq_num_alloc cycle %0d: commit %0d while empty",
               cycle_cnt_q, bus.commit_seq_num);
      end else if (bus.commit_val && (bus.commit_seq_num != head_seq)) begin
        $error("seq_num_alloc cycle %0d: commit %0d but head is %0d",
               cycle_cnt_q, bus.commit_seq_num, head_seq);
      end
      if (bus.squash_val && !squash_ok) begin
        $error("seq_num_alloc cycle %0d: squash %0d outside window head %0d count %0d",
               cycle_cnt_q, bus.squash_seq_num, head_seq, occupancy);
      end
      if (bus.alloc_val && !bus.alloc_rdy) begin
        $error("seq_num_alloc cycle %0d: alloc dropped, seq %0d not ready",
               cycle_cnt_q, bus.alloc_seq_num);
      end
    end
  end

  function automatic string trace(input int level);
    if (level > 0) begin
      return $sformatf("%0d:%0d:%0d", head_ptr, tail_ptr, occupancy);
    end
    return $sformatf("%0d", occupancy);
  endfunction
`else
  function automatic string trace(input int level);
    return (level > 0) ? $sformatf("%0d", occupancy) : $sformatf("%0d", occupancy);
  endfunction
`endif

endmodule

// File: tb/tb_seq_num_alloc.sv
// Self-checking bench for seq_num_alloc: directed vectors on a 3-bit instance
// and a randomised mix against a queue model on a 5-bit instance. Expectations
// go into a scoreboard queue; a negedge monitor pops and compares them.
module tb_seq_num_alloc;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seq_num_alloc_if #(.p_seq_num_bits(3)) bus3 ();
  seq_num_alloc_if #(.p_seq_num_bits(5)) bus5 ();

  seq_num_alloc #(.p_seq_num_bits(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  seq_num_alloc #(.p_seq_num_bits(5)) u_dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5.slave)
  );

  typedef struct {
    int    cyc;
    int    sel;
    int    rdy;
    int    alloc;
    int    head;
    int    count;
    int    cap;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;

  int   a_rdy, a_alloc, a_head, a_count, a_full, a_empty;

  // Cycle stamp so each expectation is matched to the cycle it was issued in
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  function automatic void checkOutput(input string name, input string tag,
                                      input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("[TB] FAIL %s (%s) at cycle %0d: actual=%0d expected=%0d",
               name, tag, cyc, act, exp);
    end
  endfunction

  // Monitor: compare the outputs of the current cycle against the scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.sel == 3) begin
        a_rdy   = int'(bus3.alloc_rdy);
        a_alloc = int'(bus3.alloc_seq_num);
        a_head  = int'(bus3.head_seq_num);
        a_count = int'(bus3.num_in_flight);
        a_full  = int'(bus3.full);
        a_empty = int'(bus3.empty);
      end else begin
        a_rdy   = int'(bus5.alloc_rdy);
        a_alloc = int'(bus5.alloc_seq_num);
        a_head  = int'(bus5.head_seq_num);
        a_count = int'(bus5.num_in_flight);
        a_full  = int'(bus5.full);
        a_empty = int'(bus5.empty);
      end
      checkOutput("cycle_align", mon_e.tag, cyc, mon_e.cyc);
      checkOutput("alloc_rdy", mon_e.tag, a_rdy, mon_e.rdy);
      checkOutput("alloc_seq_num", mon_e.tag, a_alloc, mon_e.alloc);
      checkOutput("head_seq_num", mon_e.tag, a_head, mon_e.head);
      checkOutput("num_in_flight", mon_e.tag, a_count, mon_e.count);
      checkOutput("full", mon_e.tag, a_full, (mon_e.count == mon_e.cap) ? 1 : 0);
      checkOutput("empty", mon_e.tag, a_empty, (mon_e.count == 0) ? 1 : 0);
    end
  end

  task automatic clearInputs();
    bus3.alloc_val = 1'b0; bus3.commit_val = 1'b0; bus3.commit_seq_num = '0;
    bus3.squash_val = 1'b0; bus3.squash_seq_num = '0;
    bus5.alloc_val = 1'b0; bus5.commit_val = 1'b0; bus5.commit_seq_num = '0;
    bus5.squash_val = 1'b0; bus5.squash_seq_num = '0;
  endtask

  task automatic doReset(input int cycles);
    clearInputs();
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Drive one cycle of inputs and queue the outputs expected during it
  task automatic applyStimulus(input int sel, input bit av, input bit cv, input int cs,
                               input bit sv, input int ss, input int e_alloc,
                               input int e_head, input int e_count, input string tag);
    exp_t e;
    if (sel == 3) begin
      bus3.alloc_val = av; bus3.commit_val = cv; bus3.commit_seq_num = 3'(cs);
      bus3.squash_val = sv; bus3.squash_seq_num = 3'(ss);
      e.cap = 8;
    end else begin
      bus5.alloc_val = av; bus5.commit_val = cv; bus5.commit_seq_num = 5'(cs);
      bus5.squash_val = sv; bus5.squash_seq_num = 5'(ss);
      e.cap = 32;
    end
    e.cyc   = cyc;
    e.sel   = sel;
    e.rdy   = ((e_count != e.cap) && !sv) ? 1 : 0;
    e.alloc = e_alloc;
    e.head  = e_head;
    e.count = e_count;
    e.tag   = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  int mq[$];
  int next_seq;

  initial begin
    doReset(2);
    $display("[TB] directed vectors, 3-bit window");

    applyStimulus(3, 0, 0, 0, 0, 0, 0, 0, 0, "reset_state");
    for (int i = 0; i < 4; i++) applyStimulus(3, 1, 0, 0, 0, 0, i, 0, i, "alloc_first4");
    applyStimulus(3, 0, 0, 0, 0, 0, 4, 0, 4, "after_4_allocs");
    for (int i = 4; i < 8; i++) applyStimulus(3, 1, 0, 0, 0, 0, i, 0, i, "alloc_to_full");
    applyStimulus(3, 0, 0, 0, 0, 0, 0, 0, 8, "full_idle");
    applyStimulus(3, 1, 1, 0, 0, 0, 0, 0, 8, "full_commit_alloc");
    applyStimulus(3, 1, 0, 0, 0, 0, 0, 1, 7, "wrapped_alloc");
    applyStimulus(3, 0, 0, 0, 0, 0, 1, 1, 8, "refull");
    applyStimulus(3, 0, 1, 1, 0, 0, 1, 1, 8, "commit1");
    applyStimulus(3, 1, 1, 2, 0, 0, 1, 2, 7, "alloc_and_commit");
    applyStimulus(3, 0, 0, 0, 0, 0, 2, 3, 7, "steady");

    doReset(1);
    applyStimulus(3, 0, 0, 0, 0, 0, 0, 0, 0, "mid_op_reset");
    for (int i = 0; i < 6; i++) applyStimulus(3, 1, 0, 0, 0, 0, i, 0, i, "alloc_0_5");
    applyStimulus(3, 1, 0, 0, 1, 2, 6, 0, 6, "squash2_blocks_alloc");
    applyStimulus(3, 0, 0, 0, 0, 0, 3, 0, 3, "after_squash2");
    applyStimulus(3, 0, 0, 0, 1, 7, 3, 0, 3, "squash_out_of_window");
    applyStimulus(3, 0, 0, 0, 0, 0, 3, 0, 3, "after_squash7");
    applyStimulus(3, 0, 0, 0, 1, 2, 3, 0, 3, "squash_youngest");
    applyStimulus(3, 0, 0, 0, 0, 0, 3, 0, 3, "after_squash_youngest");
    applyStimulus(3, 1, 0, 0, 0, 0, 3, 0, 3, "alloc3");
    applyStimulus(3, 0, 1, 0, 1, 0, 4, 0, 4, "commit_squash_head");
    applyStimulus(3, 0, 0, 0, 0, 0, 1, 1, 0, "empty_after_both");
    applyStimulus(3, 0, 1, 1, 0, 0, 1, 1, 0, "commit_when_empty");
    applyStimulus(3, 0, 0, 0, 0, 0, 1, 1, 0, "after_empty_commit");
    applyStimulus(3, 1, 0, 0, 0, 0, 1, 1, 0, "alloc1");
    applyStimulus(3, 1, 0, 0, 0, 0, 2, 1, 1, "alloc2");
    applyStimulus(3, 0, 1, 3, 0, 0, 3, 1, 2, "commit_not_head");
    applyStimulus(3, 0, 0, 0, 0, 0, 3, 1, 2, "after_bad_commit");
    applyStimulus(3, 0, 1, 1, 0, 0, 3, 1, 2, "commit_head");
    applyStimulus(3, 0, 0, 0, 0, 0, 3, 2, 1, "after_good_commit");

    doReset(1);
    $display("[TB] random mix, 5-bit window");
    next_seq = 0;
    for (int i = 0; i < 200; i++) begin
      automatic bit av = ($urandom_range(0, 99) < 70);
      automatic bit cv = ($urandom_range(0, 99) < 40);
      automatic bit sv = ($urandom_range(0, 99) < 6);
      automatic int cs = (mq.size() > 0 && $urandom_range(0, 3) != 0) ?
                         mq[0] : int'($urandom_range(0, 31));
      automatic int ss = (mq.size() > 0 && $urandom_range(0, 3) != 0) ?
                         mq[$urandom_range(0, mq.size() - 1)] : int'($urandom_range(0, 31));
      automatic int ec = mq.size();
      automatic int eh = (ec > 0) ? mq[0] : next_seq;
      automatic bit fire = av && (ec != 32) && !sv;
      automatic bit c_ok = cv && (ec > 0) && (cs == eh);
      automatic int k = -1;
      applyStimulus(5, av, cv, cs, sv, ss, next_seq, eh, ec, "random_mix");
      if (sv) begin
        foreach (mq[j]) if (k < 0 && mq[j] == ss) k = j;
      end
      if (k >= 0) begin
        while (mq.size() > k + 1) void'(mq.pop_back());
        next_seq = (ss + 1) % 32;
      end
      if (c_ok) void'(mq.pop_front());
      if (fire) begin
        mq.push_back(next_seq);
        next_seq = (next_seq + 1) % 32;
      end
    end
    clearInputs();

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL scoreboard_drain: actual=%0d pending expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
